// File: rtl/reduction_arbiter_if.sv
// Request/grant/result bundle between two requesters and reduction_arbiter.
// master = requester side, slave = arbiter side.
interface reduction_arbiter_if #(
    parameter int NIBBLES = 8
);
    logic [1:0]           req;
    logic [1:0]           op0;
    logic [1:0]           op1;
    logic [4*NIBBLES-1:0] data0;
    logic [4*NIBBLES-1:0] data1;
    logic [1:0]           gnt;
    logic                 busy;
    logic [1:0]           done;
    logic                 result;
    logic                 err;

    modport master (
        output req, op0, op1, data0, data1,
        input  gnt, busy, done, result, err
    );

    modport slave (
        input  req, op0, op1, data0, data1,
        output gnt, busy, done, result, err
    );
endinterface

// File: rtl/reduction_arbiter.sv
// Two-requester round-robin arbiter that reduces the winner's vector one nibble per cycle.
// Optional feature: define REDARB_XOR_EN to support op 10 (XOR); otherwise op 10 is reserved.
module reduction_arbiter #(
    parameter int NIBBLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    reduction_arbiter_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
`ifdef REDARB_XOR_EN
    localparam logic [1:0] OP_XOR = 2'b10;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            win_q, win_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    data_q, data_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      done_q, done_d;
    logic            result_q, result_d;
    logic            err_q, err_d;
    logic            win_sel;
    logic            op_ok;
    logic            nib_red;

    // Per-nibble reductions of the latched vector; the counter selects one each RUN cycle.
    logic [NIBBLES-1:0] nib_and;
    logic [NIBBLES-1:0] nib_or;
`ifdef REDARB_XOR_EN
    logic [NIBBLES-1:0] nib_xor;
`endif

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign nib_and[gi] = &data_q[4*gi +: 4];
        assign nib_or[gi]  = |data_q[4*gi +: 4];
`ifdef REDARB_XOR_EN
        assign nib_xor[gi] = ^data_q[4*gi +: 4];
`endif
    end

    always_comb begin
        op_ok   = (op_q == OP_AND) || (op_q == OP_OR);
        nib_red = 1'b0;
        case (op_q)
            OP_AND:  nib_red = nib_and[cnt_q];
            OP_OR:   nib_red = nib_or[cnt_q];
`ifdef REDARB_XOR_EN
            OP_XOR:  nib_red = nib_xor[cnt_q];
`endif
            default: nib_red = 1'b0;
        endcase
`ifdef REDARB_XOR_EN
        if (op_q == OP_XOR) op_ok = 1'b1;
`endif
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        op_d     = op_q;
        data_d   = data_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        result_d = 1'b0;
        err_d    = 1'b0;
        win_sel  = 1'b0;

        case (state_q)
            IDLE: begin
                case (bus.req)
                    2'b01:   win_sel = 1'b0;
                    2'b10:   win_sel = 1'b1;
                    default: win_sel = ptr_q;
                endcase
                if (bus.req != 2'b00) begin
                    win_d   = win_sel;
                    op_d    = win_sel ? bus.op1 : bus.op0;
                    data_d  = win_sel ? bus.data1 : bus.data0;
                    cnt_d   = '0;
                    acc_d   = (op_d == OP_AND);
                    gnt_d   = win_sel ? 2'b10 : 2'b01;
                    state_d = RUN;
                end
            end
            RUN: begin
                case (op_q)
                    OP_AND:  acc_d = acc_q & nib_red;
                    OP_OR:   acc_d = acc_q | nib_red;
`ifdef REDARB_XOR_EN
                    OP_XOR:  acc_d = acc_q ^ nib_red;
`endif
                    default: acc_d = acc_q;
                endcase
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_NIB) begin
                    state_d  = DONE;
                    done_d   = win_q ? 2'b10 : 2'b01;
                    result_d = op_ok ? acc_d : 1'b0;
                    err_d    = ~op_ok;
                end
            end
            DONE: begin
                ptr_d   = ~win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            win_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= 1'b0;
            op_q     <= 2'b00;
            data_q   <= '0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            result_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            data_q   <= data_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
    assign bus.busy   = (state_q == RUN) || (state_q == DONE);
endmodule

// File: tb/tb_reduction_arbiter.sv
// Bench for reduction_arbiter: directed literal cases, then random traffic checked
// every cycle against a transaction-level timing/result model.
module tb_reduction_arbiter;
    localparam int N = 8;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reduction_arbiter_if #(.NIBBLES(N)) bus ();
    reduction_arbiter #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-vector reduction; returns {err, result}.
    function automatic logic [1:0] model_reduce(input logic [1:0] op, input logic [W-1:0] d);
        case (op)
            2'b00: return {1'b0, &d};
            2'b01: return {1'b0, |d};
`ifdef REDARB_XOR_EN
            2'b10: return {1'b0, ^d};
`endif
            default: return 2'b10;
        endcase
    endfunction

    // Model: a grant opens a transaction; done lands N cycles later, idle one cycle after that.
    int         m_active = 0;
    int         m_elapsed = 0;
    int         m_win = 0;
    int         m_ptr = 0;
    logic [1:0] m_pend = 2'b00;
    logic [1:0] m_gnt = 2'b00;
    logic [1:0] m_done = 2'b00;
    logic       m_busy = 1'b0;
    logic       m_res = 1'b0;
    logic       m_err = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_ptr = 0; m_gnt = 2'b00; m_done = 2'b00;
            m_busy = 1'b0; m_res = 1'b0; m_err = 1'b0;
        end else if (m_active == 0) begin
            m_done = 2'b00;
            if (bus.req != 2'b00) begin
                m_win = (bus.req == 2'b11) ? m_ptr : ((bus.req == 2'b10) ? 1 : 0);
                m_pend = model_reduce(m_win ? bus.op1 : bus.op0, m_win ? bus.data1 : bus.data0);
                m_active = 1;
                m_elapsed = 0;
                m_gnt = m_win ? 2'b10 : 2'b01;
                m_busy = 1'b1;
            end else begin
                m_gnt = 2'b00;
                m_busy = 1'b0;
            end
        end else begin
            m_elapsed++;
            m_gnt = 2'b00;
            if (m_elapsed == N) begin
                m_done = m_win ? 2'b10 : 2'b01;
                {m_err, m_res} = m_pend;
            end else if (m_elapsed == N + 1) begin
                m_active = 0;
                m_done = 2'b00;
                m_busy = 1'b0;
                m_ptr = 1 - m_win;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", bus.gnt, m_gnt);
            check("busy", bus.busy, m_busy);
            check("done", bus.done, m_done);
            if (m_done != 2'b00) begin
                check("result", bus.result, m_res);
                check("err", bus.err, m_err);
            end
        end
    end

    // Waits (bounded) for a nonzero gnt (which=0) or done (which=1); t = negedges waited.
    task automatic wait_sig(input bit which, output int t);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (((which ? bus.done : bus.gnt) == 2'b00) && t < 40);
    endtask

    task automatic directed(input string name, input logic [1:0] r, input logic [1:0] op,
                            input logic [W-1:0] d, input logic exp_res, input logic exp_err);
        int t;
        if (r[0]) begin bus.op0 = op; bus.data0 = d; end
        else      begin bus.op1 = op; bus.data1 = d; end
        bus.req = r;
        wait_sig(1'b0, t);
        check({name, "_gnt"}, bus.gnt, r);
        wait_sig(1'b1, t);
        check({name, "_lat"}, t, N);
        check({name, "_done"}, bus.done, r);
        check({name, "_res"}, bus.result, exp_res);
        check({name, "_err"}, bus.err, exp_err);
        bus.req = 2'b00;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] v;
        case ($urandom_range(0, 4))
            0: v = '1;
            1: v = ~(W'(1) << $urandom_range(0, W - 1));
            2: v = '0;
            3: v = W'(1) << $urandom_range(0, W - 1);
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int t;
        bus.req = 2'b00; bus.op0 = 2'b00; bus.op1 = 2'b00;
        bus.data0 = '0;  bus.data1 = '0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_gnt", bus.gnt, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 2'b00);
        check("rst_result", bus.result, 1'b0);
        check("rst_err", bus.err, 1'b0);
        rst = 1'b0;

        directed("and_ones", 2'b01, 2'b00, 32'hFFFF_FFFF, 1'b1, 1'b0);
        directed("and_fe",   2'b01, 2'b00, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("or_100",   2'b10, 2'b01, 32'h0000_0100, 1'b1, 1'b0);
        directed("or_zero",  2'b10, 2'b01, 32'h0000_0000, 1'b0, 1'b0);
`ifdef REDARB_XOR_EN
        directed("xor_7",    2'b01, 2'b10, 32'h0000_0007, 1'b1, 1'b0);
        directed("xor_3",    2'b01, 2'b10, 32'h0000_0003, 1'b0, 1'b0);
`else
        directed("xor_7",    2'b01, 2'b10, 32'h0000_0007, 1'b0, 1'b1);
        directed("xor_3",    2'b01, 2'b10, 32'h0000_0003, 1'b0, 1'b1);
`endif
        directed("rsvd",     2'b01, 2'b11, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Both requesting after reset: requester 0 first, then requester 1.
        pulse_reset();
        bus.op0 = 2'b00; bus.data0 = 32'hFFFF_FFFF;
        bus.op1 = 2'b01; bus.data1 = 32'h0000_0000;
        bus.req = 2'b11;
        wait_sig(1'b0, t);
        check("rr_gnt0", bus.gnt, 2'b01);
        wait_sig(1'b1, t);
        check("rr_done0", bus.done, 2'b01);
        check("rr_res0", bus.result, 1'b1);
        bus.req = 2'b10;
        wait_sig(1'b0, t);
        check("rr_gap", t, 2);
        check("rr_gnt1", bus.gnt, 2'b10);
        wait_sig(1'b1, t);
        check("rr_done1", bus.done, 2'b10);
        check("rr_res1", bus.result, 1'b0);
        bus.req = 2'b00;
        @(negedge clk);

        // Reset in the third RUN cycle abandons the operation.
        pulse_reset();
        bus.req = 2'b11;
        wait_sig(1'b0, t);
        check("ab_gnt", bus.gnt, 2'b01);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ab_busy", bus.busy, 1'b0);
        check("ab_done", bus.done, 2'b00);
        rst = 1'b0;
        wait_sig(1'b0, t);
        check("ab_regnt", bus.gnt, 2'b01);
        wait_sig(1'b1, t);
        bus.req = 2'b00;
        @(negedge clk);

        // Random traffic: requesters hold req until their done, ops/data scrambled anytime.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 2; i++) begin
                if (bus.req[i] && bus.done[i]) bus.req[i] = 1'b0;
                else if (!bus.req[i] && $urandom_range(0, 3) == 0) bus.req[i] = 1'b1;
                if ($urandom_range(0, 5) == 0) begin
                    if (i == 0) begin bus.op0 = 2'($urandom); bus.data0 = rand_data(); end
                    else        begin bus.op1 = 2'($urandom); bus.data1 = rand_data(); end
                end
            end
            @(negedge clk);
        end
        rst = 1'b0;
        bus.req = 2'b00;
        repeat (N + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
